// File: rtl/pcs25g_cdr_pkg.sv
// Shared types and helpers for the 25G PCS clock-recovery lock controller.
package pcs25g_cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } cdr_state_e;

  localparam int CDR_CNT_W = 16;

  typedef struct packed {
    logic viol;
    logic hit;
  } tol_cmp_t;

  // Classifies a run length against the UI estimate using a saturated window.
  // Arguments are zero-extended to 32 bits; max_val is the all-ones value of
  // the caller's run-length width so the upper bound saturates there.
  function automatic tol_cmp_t tol_compare(input logic [31:0] sample,
                                           input logic [31:0] period,
                                           input logic [31:0] tol,
                                           input logic [31:0] max_val);
    logic [31:0] lo;
    logic [31:0] hi;
    logic [32:0] sum;
    tol_cmp_t    res;
    lo       = (period >= tol) ? (period - tol) : 32'd0;
    sum      = {1'b0, period} + {1'b0, tol};
    hi       = (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    res.viol = (sample < lo);
    res.hit  = (sample >= lo) && (sample <= hi);
    return res;
  endfunction

endpackage

// File: rtl/cdr_edge_watchdog.sv
// Edge-activity watchdog: counts cycles since the last accepted edge and
// raises a one-cycle expire when TIMEOUT cycles pass without one.
module cdr_edge_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // A clear in the expiry cycle suppresses the expiry (the edge wins).
  assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

  // Idle-cycle counter; restarts on clear, expiry or when disabled.
  always_ff @(posedge clk) begin
    if (rst || !en_i || clr_i || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// Acquisition and lock controller for the behavioural clock-recovery path:
// minimum-run UI estimation, verification, lock and loss-of-lock recovery.
module cdr_lock_ctrl
  import pcs25g_cdr_pkg::*;
#(
  parameter int CNT_W        = CDR_CNT_W,
  parameter int WIN          = 32,
  parameter int VERIFY_EDGES = 64,
  parameter int MIN_HITS     = 16,
  parameter int TOL          = 2,
  parameter int LOSS_MAX     = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             edge_vld,
  input  logic [CNT_W-1:0] edge_int,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld,
  output logic             gen_restart,
  output logic             locked,
  output logic [1:0]       state_o,
  output logic [7:0]       loss_cnt
);

  localparam int EMAX = (WIN > VERIFY_EDGES) ? WIN : VERIFY_EDGES;
  localparam int ECW  = $clog2(EMAX + 1);
  localparam int HCW  = $clog2(VERIFY_EDGES + 1);
  localparam int BCW  = $clog2(LOSS_MAX + 1);

  cdr_state_e       state_q;
  logic [CNT_W-1:0] period_q;
  logic             period_vld_q;
  logic             gen_restart_q;
  logic             locked_q;
  logic [7:0]       loss_q;
  logic [CNT_W-1:0] min_q;
  logic [ECW-1:0]   edge_cnt_q;
  logic [HCW-1:0]   hit_cnt_q;
  logic [BCW-1:0]   bad_cnt_q;

  logic             accepted;
  logic             wd_expire;
  tol_cmp_t         cmp;
  logic [CNT_W-1:0] min_d;
  logic [HCW-1:0]   hit_cnt_d;

  // A zero interval is a glitch and is never treated as an edge.
  assign accepted = edge_vld && (edge_int != '0);

  assign cmp = tol_compare(32'(edge_int), 32'(period_q), 32'(TOL),
                           32'({CNT_W{1'b1}}));

  assign min_d = (edge_int < min_q) ? edge_int : min_q;

  // Hit count including the current edge, saturating.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (cmp.hit && (hit_cnt_q != {HCW{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  cdr_edge_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .en_i     (enable && (state_q != ST_IDLE)),
    .clr_i    (accepted),
    .expire_o (wd_expire)
  );

  // Acquisition state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      period_vld_q  <= 1'b0;
      gen_restart_q <= 1'b0;
      locked_q      <= 1'b0;
      loss_q        <= '0;
      min_q         <= '1;
      edge_cnt_q    <= '0;
      hit_cnt_q     <= '0;
      bad_cnt_q     <= '0;
    end else begin
      gen_restart_q <= 1'b0;
      if (!enable) begin
        state_q      <= ST_IDLE;
        period_vld_q <= 1'b0;
        locked_q     <= 1'b0;
      end else if (wd_expire) begin
        state_q      <= ST_ACQ;
        period_vld_q <= 1'b0;
        locked_q     <= 1'b0;
        min_q        <= '1;
        edge_cnt_q   <= '0;
        hit_cnt_q    <= '0;
        bad_cnt_q    <= '0;
        if ((state_q == ST_LOCKED) && (loss_q != 8'hFF)) begin
          loss_q <= loss_q + 8'd1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_ACQ;
            min_q      <= '1;
            edge_cnt_q <= '0;
            hit_cnt_q  <= '0;
            bad_cnt_q  <= '0;
          end
          ST_ACQ: begin
            if (accepted) begin
              min_q <= min_d;
              if (edge_cnt_q == ECW'(WIN - 1)) begin
                state_q       <= ST_VERIFY;
                period_q      <= min_d;
                period_vld_q  <= 1'b1;
                gen_restart_q <= 1'b1;
                edge_cnt_q    <= '0;
                hit_cnt_q     <= '0;
              end else begin
                edge_cnt_q <= edge_cnt_q + 1'b1;
              end
            end
          end
          ST_VERIFY: begin
            if (accepted) begin
              if (cmp.viol) begin
                state_q      <= ST_ACQ;
                period_vld_q <= 1'b0;
                min_q        <= '1;
                edge_cnt_q   <= '0;
                hit_cnt_q    <= '0;
              end else if (edge_cnt_q == ECW'(VERIFY_EDGES - 1)) begin
                edge_cnt_q <= '0;
                hit_cnt_q  <= '0;
                bad_cnt_q  <= '0;
                if (hit_cnt_d >= HCW'(MIN_HITS)) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  state_q      <= ST_ACQ;
                  period_vld_q <= 1'b0;
                  min_q        <= '1;
                end
              end else begin
                edge_cnt_q <= edge_cnt_q + 1'b1;
                hit_cnt_q  <= hit_cnt_d;
              end
            end
          end
          ST_LOCKED: begin
            if (accepted) begin
              if (!cmp.viol) begin
                bad_cnt_q <= '0;
              end else if (bad_cnt_q == BCW'(LOSS_MAX - 1)) begin
                state_q      <= ST_ACQ;
                locked_q     <= 1'b0;
                period_vld_q <= 1'b0;
                min_q        <= '1;
                edge_cnt_q   <= '0;
                hit_cnt_q    <= '0;
                bad_cnt_q    <= '0;
                if (loss_q != 8'hFF) begin
                  loss_q <= loss_q + 8'd1;
                end
              end else begin
                bad_cnt_q <= bad_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign period_o    = period_q;
  assign period_vld  = period_vld_q;
  assign gen_restart = gen_restart_q;
  assign locked      = locked_q;
  assign state_o     = state_q;
  assign loss_cnt    = loss_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Directed bench for cdr_lock_ctrl: acquisition, verification, lock,
// loss-of-lock, watchdog, glitch, enable and reset behaviour.
module tb_cdr_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        edge_vld;
  logic [15:0] edge_int;
  logic [15:0] period_o;
  logic        period_vld;
  logic        gen_restart;
  logic        locked;
  logic [1:0]  state_o;
  logic [7:0]  loss_cnt;

  int total = 0;
  int bad = 0;
  int restartCount = 0;
  int acqPat[3] = '{30, 10, 20};
  int verPat[4] = '{10, 20, 10, 30};

  cdr_lock_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .edge_vld    (edge_vld),
    .edge_int    (edge_int),
    .period_o    (period_o),
    .period_vld  (period_vld),
    .gen_restart (gen_restart),
    .locked      (locked),
    .state_o     (state_o),
    .loss_cnt    (loss_cnt)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Counts restart pulses; a one-cycle pulse spans exactly one falling edge.
  always @(negedge clk) begin
    if (gen_restart === 1'b1) restartCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One edge strobe; returns just after the capturing clock edge.
  task automatic applyStimulus(input logic [15:0] val);
    @(negedge clk);
    edge_vld = 1'b1;
    edge_int = val;
    @(posedge clk);
    #1;
    edge_vld = 1'b0;
    edge_int = '0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 32 acquisition edges cycling 30,10,20 with a glitch mixed in.
  task automatic acquire();
    for (int i = 0; i < 32; i++) begin
      if (i == 12) applyStimulus(16'd0);
      applyStimulus(16'(acqPat[i % 3]));
      if (i == 30) begin
        checkOutput("acq_state_31", 32'(state_o), 32'd1);
        checkOutput("acq_vld_31", 32'(period_vld), 32'd0);
      end
    end
    checkOutput("acq_state_32", 32'(state_o), 32'd2);
    checkOutput("acq_period", 32'(period_o), 32'd10);
    checkOutput("acq_vld_32", 32'(period_vld), 32'd1);
    checkOutput("acq_restart", 32'(gen_restart), 32'd1);
  endtask

  // 64 verification edges cycling 10,20,10,30 with a glitch mixed in.
  task automatic verifyLock(input int expRestarts);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) applyStimulus(16'd0);
      applyStimulus(16'(verPat[i % 4]));
      if (i == 0) begin
        checkOutput("ver_restart_low", 32'(gen_restart), 32'd0);
        checkOutput("ver_restart_cnt", 32'(restartCount), 32'(expRestarts));
      end
      if (i == 62) begin
        checkOutput("ver_state_63", 32'(state_o), 32'd2);
        checkOutput("ver_locked_63", 32'(locked), 32'd0);
      end
    end
    checkOutput("lock_state", 32'(state_o), 32'd3);
    checkOutput("lock_locked", 32'(locked), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    edge_vld = 1'b0;
    edge_int = '0;
    idleCycles(2);
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_period", 32'(period_o), 32'd0);
    checkOutput("rst_vld", 32'(period_vld), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_restart", 32'(gen_restart), 32'd0);
    checkOutput("rst_loss", 32'(loss_cnt), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd0);
    checkOutput("idle_disabled", 32'(state_o), 32'd0);

    @(negedge clk);
    enable = 1'b1;
    idleCycles(1);
    checkOutput("enter_acq", 32'(state_o), 32'd1);

    acquire();
    verifyLock(1);

    // Loss of lock by four consecutive short runs
    applyStimulus(16'd5);
    applyStimulus(16'd5);
    applyStimulus(16'd5);
    checkOutput("bad3_locked", 32'(locked), 32'd1);
    applyStimulus(16'd10);
    checkOutput("good_locked", 32'(locked), 32'd1);
    applyStimulus(16'd5);
    applyStimulus(16'd5);
    applyStimulus(16'd0);
    applyStimulus(16'd5);
    checkOutput("bad3b_locked", 32'(locked), 32'd1);
    checkOutput("bad3b_state", 32'(state_o), 32'd3);
    applyStimulus(16'd5);
    checkOutput("loss_locked", 32'(locked), 32'd0);
    checkOutput("loss_state", 32'(state_o), 32'd1);
    checkOutput("loss_cnt1", 32'(loss_cnt), 32'd1);
    checkOutput("loss_vld", 32'(period_vld), 32'd0);

    // Verification violation just below the window
    acquire();
    applyStimulus(16'd8);
    checkOutput("ver_lo_edge", 32'(state_o), 32'd2);
    checkOutput("ver_restart2", 32'(restartCount), 32'd2);
    applyStimulus(16'd7);
    checkOutput("viol_state", 32'(state_o), 32'd1);
    checkOutput("viol_vld", 32'(period_vld), 32'd0);
    checkOutput("viol_restart", 32'(gen_restart), 32'd0);

    // Watchdog expiry from lock
    acquire();
    verifyLock(3);
    idleCycles(4095);
    checkOutput("wd_pre_state", 32'(state_o), 32'd3);
    idleCycles(1);
    checkOutput("wd_state", 32'(state_o), 32'd1);
    checkOutput("wd_locked", 32'(locked), 32'd0);
    checkOutput("wd_loss", 32'(loss_cnt), 32'd2);

    // Edge arriving on the expiry cycle keeps lock
    acquire();
    verifyLock(4);
    idleCycles(4095);
    applyStimulus(16'd10);
    checkOutput("wd_edge_state", 32'(state_o), 32'd3);
    checkOutput("wd_edge_locked", 32'(locked), 32'd1);
    idleCycles(4095);
    checkOutput("wd_cleared", 32'(state_o), 32'd3);

    // Disable while locked
    @(negedge clk);
    enable = 1'b0;
    idleCycles(1);
    checkOutput("dis_state", 32'(state_o), 32'd0);
    checkOutput("dis_locked", 32'(locked), 32'd0);
    checkOutput("dis_loss", 32'(loss_cnt), 32'd2);
    checkOutput("dis_period", 32'(period_o), 32'd10);
    applyStimulus(16'd0);
    checkOutput("idle_glitch", 32'(state_o), 32'd0);

    // Reset in the middle of verification, with an edge in the reset cycle
    @(negedge clk);
    enable = 1'b1;
    idleCycles(1);
    acquire();
    applyStimulus(16'd10);
    applyStimulus(16'd10);
    @(negedge clk);
    rst      = 1'b1;
    edge_vld = 1'b1;
    edge_int = 16'd7;
    @(posedge clk);
    #1;
    edge_vld = 1'b0;
    edge_int = '0;
    checkOutput("mid_rst_state", 32'(state_o), 32'd0);
    checkOutput("mid_rst_period", 32'(period_o), 32'd0);
    checkOutput("mid_rst_vld", 32'(period_vld), 32'd0);
    checkOutput("mid_rst_locked", 32'(locked), 32'd0);
    checkOutput("mid_rst_loss", 32'(loss_cnt), 32'd0);
    checkOutput("mid_rst_restart", 32'(gen_restart), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
